// File: rtl/inter_pe_psum_buffer.sv
// Tagged partial-sum staging buffer between adjacent PE columns.
// Head columns match entries by (id, phase); follower columns replay upstream slot positions.
module inter_pe_psum_buffer #(
  parameter  int DEPTH   = 4,
  parameter  int LANES   = 2,
  parameter  int DATA_W  = 32,
  parameter  int ID_W    = 8,
  parameter  int PHASE_W = 4,
  parameter  int IS_HEAD = 1,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES*ID_W-1:0]      in_id,
  input  logic [LANES*PHASE_W-1:0]   in_phase,
  input  logic [LANES*DATA_W-1:0]    in_data,
  input  logic                       req_valid,
  input  logic [LANES*ID_W-1:0]      req_id,
  input  logic [PHASE_W-1:0]         req_phase,
  input  logic                       pos_in_valid,
  input  logic [LANES*PW-1:0]        pos_in,
  output logic [LANES-1:0]           out_valid,
  output logic [LANES*DATA_W-1:0]    out_data,
  output logic                       pos_out_valid,
  output logic [LANES*PW-1:0]        pos_out,
  output logic [CW-1:0]              occupancy,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  logic [DEPTH-1:0]   r_valid;
  logic [ID_W-1:0]    r_id    [DEPTH];
  logic [PHASE_W-1:0] r_phase [DEPTH];
  logic [DATA_W-1:0]  r_data  [DEPTH];

  logic [DEPTH-1:0]   w_valid_n;
  logic [ID_W-1:0]    w_id_n    [DEPTH];
  logic [PHASE_W-1:0] w_phase_n [DEPTH];
  logic [DATA_W-1:0]  w_data_n  [DEPTH];

  logic [LANES-1:0]        w_out_valid;
  logic [LANES*DATA_W-1:0] w_out_data;
  logic [LANES*PW-1:0]     w_pos_out;
  logic                    w_pos_vld;
  logic                    w_ovf;
  logic [LANES-1:0]        w_need_alloc;
  logic [DEPTH-1:0]        w_taken;
  logic                    w_found;
  logic [PW-1:0]           w_slot;
  logic [CW-1:0]           w_cnt;

  // Slot update: reads always see the old state, then hits/positions rewrite or clear,
  // then leftover writes take the lowest free slots in lane order.
  always_comb begin
    w_valid_n    = r_valid;
    w_out_valid  = '0;
    w_out_data   = '0;
    w_pos_out    = '0;
    w_pos_vld    = 1'b0;
    w_ovf        = 1'b0;
    w_need_alloc = '0;
    w_taken      = '0;
    w_found      = 1'b0;
    w_slot       = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_id_n[j]    = r_id[j];
      w_phase_n[j] = r_phase[j];
      w_data_n[j]  = r_data[j];
    end

    if (IS_HEAD == 0 && pos_in_valid) begin
      w_pos_vld = 1'b1;
      w_pos_out = pos_in;
      for (int l = 0; l < LANES; l++) begin
        w_slot                          = pos_in[l*PW +: PW];
        w_out_valid[l]                  = r_valid[w_slot];
        w_out_data[l*DATA_W +: DATA_W]  = r_data[w_slot];
        w_valid_n[w_slot]               = in_valid[l];
        if (in_valid[l]) begin
          w_id_n[w_slot]    = in_id[l*ID_W +: ID_W];
          w_phase_n[w_slot] = in_phase[l*PHASE_W +: PHASE_W];
          w_data_n[w_slot]  = in_data[l*DATA_W +: DATA_W];
        end
      end
    end else if (IS_HEAD != 0 && req_valid) begin
      w_pos_vld = 1'b1;
      for (int l = 0; l < LANES; l++) begin
        w_found = 1'b0;
        w_slot  = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
          if (r_valid[j] && r_id[j] == req_id[l*ID_W +: ID_W] && r_phase[j] == req_phase) begin
            w_found = 1'b1;
            w_slot  = PW'(j);
          end
        end
        if (w_found && !w_taken[w_slot]) begin
          w_taken[w_slot]                = 1'b1;
          w_out_valid[l]                 = 1'b1;
          w_out_data[l*DATA_W +: DATA_W] = r_data[w_slot];
          w_pos_out[l*PW +: PW]          = w_slot;
          w_valid_n[w_slot]              = in_valid[l];
          if (in_valid[l]) begin
            w_id_n[w_slot]    = in_id[l*ID_W +: ID_W];
            w_phase_n[w_slot] = in_phase[l*PHASE_W +: PHASE_W];
            w_data_n[w_slot]  = in_data[l*DATA_W +: DATA_W];
          end
        end else begin
          w_need_alloc[l] = in_valid[l];
        end
      end
    end else begin
      w_need_alloc = in_valid;
      if (IS_HEAD == 0) begin
        w_pos_out = pos_in;
      end
    end

    for (int l = 0; l < LANES; l++) begin
      if (w_need_alloc[l]) begin
        w_found = 1'b0;
        w_slot  = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
          if (!w_valid_n[j]) begin
            w_found = 1'b1;
            w_slot  = PW'(j);
          end
        end
        if (w_found) begin
          w_valid_n[w_slot] = 1'b1;
          w_id_n[w_slot]    = in_id[l*ID_W +: ID_W];
          w_phase_n[w_slot] = in_phase[l*PHASE_W +: PHASE_W];
          w_data_n[w_slot]  = in_data[l*DATA_W +: DATA_W];
          if (IS_HEAD != 0 && !req_valid) begin
            w_pos_out[l*PW +: PW] = w_slot;
            w_pos_vld             = 1'b1;
          end
        end else begin
          w_ovf = 1'b1;
        end
      end
    end

    // Flush discards this cycle's writes but leaves the reads above intact.
    if (flush) begin
      w_valid_n = '0;
      w_ovf     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid       <= '0;
      out_valid     <= '0;
      out_data      <= '0;
      pos_out_valid <= 1'b0;
      pos_out       <= '0;
      overflow      <= 1'b0;
    end else begin
      r_valid       <= w_valid_n;
      out_valid     <= w_out_valid;
      out_data      <= w_out_data;
      pos_out_valid <= w_pos_vld;
      pos_out       <= w_pos_out;
      overflow      <= overflow | w_ovf;
    end
  end

  // Slot payload is qualified by r_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) begin
      r_id[j]    <= w_id_n[j];
      r_phase[j] <= w_phase_n[j];
      r_data[j]  <= w_data_n[j];
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_cnt = w_cnt + CW'(r_valid[j]);
    end
  end

  assign occupancy = w_cnt;
  assign full      = (w_cnt == CW'(DEPTH));
  assign empty     = (w_cnt == '0);

endmodule

// File: doc/inter_pe_psum_buffer.md
# inter_pe_psum_buffer

Parametrised partial-sum staging buffer between adjacent PE columns of the MXU. It holds up to DEPTH tagged partial-sum entries and serves LANES lanes per cycle. In head mode it matches requests by (id, phase) tag and publishes slot positions; in follower mode it replays those positions one hop downstream. Compared with the fixed 2-lane/4-slot buffer it adds per-slot valid tracking, free-slot allocation, occupancy/full/empty status, a flush, and a sticky overflow flag.

## Interface
- DEPTH, 4, number of slots; power of 2, ≥ 2.
- LANES, 2, entries written and read per cycle; 1 ≤ LANES ≤ DEPTH.
- DATA_W, 32, partial-sum width.
- ID_W, 8, tag id width.
- PHASE_W, 4, tag phase width.
- IS_HEAD, 1, 1 = tag-matching head column; 0 = position-following column.
- PW = $clog2(DEPTH), CW = $clog2(DEPTH+1) (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  invalidate all slots.
- in_valid  in  LANES  per-lane write-entry valid.
- in_id  in  LANES×ID_W  per-lane write-entry id.
- in_phase  in  LANES×PHASE_W  per-lane write-entry phase.
- in_data  in  LANES×DATA_W  per-lane write-entry data.
- req_valid  in  1  head mode: match request valid.
- req_id  in  LANES×ID_W  head mode: id to match, per lane.
- req_phase  in  PHASE_W  head mode: phase to match, shared by all lanes.
- pos_in_valid  in  1  follower mode: upstream position bundle valid.
- pos_in  in  LANES×PW  follower mode: upstream slot positions.
- out_valid  out  LANES  per-lane result valid (registered).
- out_data  out  LANES×DATA_W  per-lane result data (registered).
- pos_out_valid  out  1  position bundle valid for the next column (registered).
- pos_out  out  LANES×PW  slot position per lane (registered).
- occupancy  out  CW  number of valid slots.
- full  out  1  occupancy == DEPTH.
- empty  out  1  occupancy == 0.
- overflow  out  1  sticky; set when a valid write finds no free slot.

## Operation
- Slot state: valid, id, phase, data. The ID_W/PHASE_W tag fields exist in both modes.
- Head mode (IS_HEAD=1), cycle with req_valid=1:
  - Each lane l searches for a valid slot with id==req_id[l] and phase==req_phase. On multiple matches, the lowest index wins.
  - If lanes l<m hit the same slot, lane l takes it and lane m is a miss.
  - On a hit: out_valid[l]=1, out_data[l]=slot data, pos_out[l]=slot index. The slot is then rewritten with lane l's in_* entry if in_valid[l]=1, otherwise it is invalidated.
  - On a miss: out_valid[l]=0, pos_out[l]=0, and lane l's write falls through to allocation.
- Head mode, req_valid=0: each lane with in_valid is allocated the lowest-index free slot, lane 0 first. pos_out[l] = allocated index.
- pos_out_valid=1 when req_valid=1 or any write was allocated.
- Follower mode (IS_HEAD=0): when pos_in_valid=1, lane l reads slot pos_in[l] (out_valid[l] = slot valid), then writes lane l's in_* entry there if in_valid[l]=1, otherwise clears it. pos_out/pos_out_valid forward pos_in/pos_in_valid. If pos_in_valid=0, in_* entries are allocated as in head mode.
- Allocation failure (no free slot): the entry is dropped and overflow is set. Overflow clears only on reset.
- Write-after-read into the same slot in the same cycle is legal; the read returns the old data.
- flush=1: all slots invalid at the next edge. In-flight reads that cycle still return data. Same-cycle writes are discarded.
- Reset (rst_n=0 at an edge): all slots invalid; out_valid=0, out_data=0, pos_out_valid=0, pos_out=0, overflow=0; hence occupancy=0, empty=1, full=0. Reset has priority over flush and over all traffic, including mid-request.

## Timing
- All outputs except occupancy/full/empty are registered.
- Request or pos_in sampled at edge t → out_* and pos_out* valid during cycle t+1. Latency is 1.
- occupancy/full/empty are combinational decodes of slot valid bits and reflect edge-t updates in cycle t+1.
- One request per cycle; back-to-back requests are sustained at full rate.
- There is no backpressure. Upstream must respect full.

## Test plan
- Reset, then DEPTH=4/LANES=2 head mode: write ids 5,6 (phase 1), then 7,8 → occupancy=4, full=1. A further write of id 9 → dropped, overflow=1, stays 1.
- Head mode: req_id={6,5}, phase 1, with in_valid=0 → next cycle out_valid=2'b11, out_data equals the stored values, pos_out={1,0}, occupancy=2.
- Head mode: both lanes request id 7 → lane 0 hits slot 2, lane 1 out_valid=0. Wrong phase → both lanes miss.
- Follower mode: pos_in={3,0}, pos_in_valid=1 → cycle+1 out_data = slots 3 and 0, pos_out={3,0}. Slots 3 and 0 hold the new in_data.
- flush together with a write → occupancy=0 next cycle, write discarded.
- rst_n low mid-request → all outputs 0 next cycle.
